verificador_de_senha: RTL and testbench
=======================================

// Module: verificador_de_senha
// PURPOSE
// Password checker and lock controller, directly downstream of the keypad decoder.
// Takes each 20-digit packet the decoder publishes and compares it with the stored password.
// Drives the lock output and counts failed attempts, with lockout after too many failures.
// Supports in-field password change: a 'B' packet, then the current password, then the new one.
// PARAMETERS
// MIN_LEN         4                         minimum accepted password length (digits)
// MAX_LEN         12                        maximum accepted password length (digits), <=20
// MAX_TENTATIVAS  3                         consecutive failures that trigger lockout
// T_ABERTO        5000                      cycles tranca_aberta stays high after a match
// T_BLOQUEIO      20000                     cycles of lockout
// SENHA_PADRAO    {16{4'hF}},16'h1234       80-bit password loaded at reset
// PORTS
// clk             in   1   clock
// rst             in   1   async reset, active-high
// digitos_value   in   80  20 x 4-bit digits; [3:0] = most recent key, 'hF = empty slot
// digitos_valid   in   1   packet valid; may stay high several cycles
// tranca_aberta   out  1   lock open
// bloqueado       out  1   lockout active
// teclado_enable  out  1   1 = keypad input allowed; 0 during lockout
// erro_pulso      out  1   1-cycle pulse: wrong, malformed or rejected entry
// senha_alterada  out  1   1-cycle pulse: new password stored
// tentativas      out  2   consecutive failure count, saturates at MAX_TENTATIVAS
// BEHAVIOUR
// - Reset (async): state IDLE, all timers 0, tentativas 0, senha_q <= SENHA_PADRAO.
//   Reset values: tranca_aberta 0, bloqueado 0, teclado_enable 1, erro_pulso 0, senha_alterada 0.
// - Capture: a packet is taken only on a rising edge of digitos_valid (valid & ~valid_q); pkt_q <= value.
//   Held-high valid never re-triggers. An all-'hF packet (decoder clear) is ignored.
// - Classification, registered in the cycle after capture:
//   all-'hB = CMD_B; all-'hE = TIMEOUT.
//   WELL-FORMED: digits [0..L-1] are all 0-9, digits [L..19] are all 'hF, MIN_LEN<=L<=MAX_LEN.
//   Anything else = MALFORMED.
// - Match: WELL-FORMED and pkt_q == senha_q, compared over the full 80 bits.
// - Latency: outputs change 2 cycles after the rising edge of valid (capture, then classify/act).
// - FSM:
//   IDLE:     match -> ABERTO, tentativas<=0.
//             WELL-FORMED mismatch or MALFORMED -> FALHA.
//             CMD_B -> CHG_AUTH.
//             TIMEOUT -> stay in IDLE, erro_pulso, no count.
//   ABERTO:   tranca_aberta=1 for exactly T_ABERTO cycles, then IDLE. Packets ignored.
//   FALHA:    1 cycle. erro_pulso=1, tentativas+1.
//             If the new count == MAX_TENTATIVAS -> BLOQUEIO, else IDLE.
//   BLOQUEIO: bloqueado=1, teclado_enable=0 for exactly T_BLOQUEIO cycles; packets ignored.
//             Exit -> IDLE, tentativas<=0.
//   CHG_AUTH: match -> CHG_NOVA. Mismatch or MALFORMED -> FALHA (counts).
//             CMD_B or TIMEOUT -> IDLE with erro_pulso, no count.
//   CHG_NOVA: WELL-FORMED -> senha_q<=pkt_q, senha_alterada pulse, tentativas<=0, IDLE.
//             Otherwise -> IDLE with erro_pulso; senha_q unchanged; no count.
// - Timers: one down-counter, width $clog2(max(T_ABERTO,T_BLOQUEIO)+1).
//   Loaded on state entry; the state exits when the counter reaches 0 (no off-by-one).
// - Simultaneous events: a rising valid edge during ABERTO or BLOQUEIO is dropped, not queued.
//   A new edge arriving while a packet is still being classified is dropped.
// - Reset mid-operation: aborts any state immediately. A changed password is lost (back to SENHA_PADRAO).
// TESTING
// - Reset, then packet ...FFFF1234 -> tranca_aberta rises 2 cycles after valid edge.
//   It stays high exactly 5000 cycles; tentativas=0.
// - Three packets ...FFFF9999 -> erro_pulso x3, tentativas 1,2,3.
//   bloqueado=1 and teclado_enable=0 for 20000 cycles; a ...1234 packet during lockout is ignored.
// - valid held high 3 cycles with ...1234, then a 1-cycle all-F packet with valid -> exactly one unlock, no error.
// - CMD_B, then ...1234, then ...FF5678 -> senha_alterada pulse.
//   Next ...1234 -> erro_pulso; next ...5678 -> unlock.
// - Malformed entries, each -> erro_pulso with tentativas+1:
//   ...F123 (too short), ...F1F34 (hole), ...FFA234 (non-decimal digit).
// - All-E packet in IDLE -> erro_pulso, tentativas unchanged.
//   rst asserted mid-ABERTO -> tranca_aberta 0 immediately, senha_q = SENHA_PADRAO.

Source files
------------

// File: rtl/verificador_de_senha.sv
// verificador_de_senha
//   Password checker and lock controller fed by the keypad decoder. Each
//   20-digit packet is captured on the rising edge of digitos_valid. It is then
//   classified and compared with the stored password, which drives the lock,
//   the failure counter and the lockout. A 'B' packet, then the current
//   password, then a new one changes the stored password.
// Ports
//   clk            clock
//   rst            async reset, active-high
//   digitos_value  20 x 4-bit digits, [3:0] = most recent key, 'hF = empty
//   digitos_valid  packet valid (may stay high for several cycles)
//   tranca_aberta  lock open
//   bloqueado      lockout active
//   teclado_enable keypad input allowed (0 during lockout)
//   erro_pulso     1-cycle pulse on a wrong, malformed or rejected entry
//   senha_alterada 1-cycle pulse when a new password is stored
//   tentativas     consecutive failure count, saturating
module verificador_de_senha #(
  parameter int          MIN_LEN        = 4,
  parameter int          MAX_LEN        = 12,
  parameter int          MAX_TENTATIVAS = 3,
  parameter int          T_ABERTO       = 5000,
  parameter int          T_BLOQUEIO     = 20000,
  parameter logic [79:0] SENHA_PADRAO   = {{16{4'hF}}, 16'h1234}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] digitos_value,
  input  logic        digitos_valid,
  output logic        tranca_aberta,
  output logic        bloqueado,
  output logic        teclado_enable,
  output logic        erro_pulso,
  output logic        senha_alterada,
  output logic [1:0]  tentativas
);

  localparam int TMAX = (T_ABERTO > T_BLOQUEIO) ? T_ABERTO : T_BLOQUEIO;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [1:0] MAX_T = 2'(MAX_TENTATIVAS);

  typedef enum logic [2:0] {
    IDLE, ABERTO, FALHA, BLOQUEIO, CHG_AUTH, CHG_NOVA
  } state_t;

  typedef enum logic [1:0] {CLS_CMD_B, CLS_TIMEOUT, CLS_WF, CLS_MAL} cls_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic          pend_reg;
  logic          valid_q;
  logic [79:0]   pkt_q;
  logic [79:0]   senha_q;

  // Per-digit decode of the captured packet and of the incoming value.
  logic [19:0] is_dec, is_f, is_b, is_e, in_is_f;

  genvar gi;
  generate
    for (gi = 0; gi < 20; gi++) begin : g_digit
      assign is_dec[gi]  = (pkt_q[4*gi +: 4] <= 4'd9);
      assign is_f[gi]    = (pkt_q[4*gi +: 4] == 4'hF);
      assign is_b[gi]    = (pkt_q[4*gi +: 4] == 4'hB);
      assign is_e[gi]    = (pkt_q[4*gi +: 4] == 4'hE);
      assign in_is_f[gi] = (digitos_value[4*gi +: 4] == 4'hF);
    end
  endgenerate

  // Well-formed: a run of decimal digits from slot 0, then only 'hF.
  logic       wf;
  logic       seen_f;
  logic       shape_ok;
  logic [4:0] len;

  always_comb begin
    seen_f   = 1'b0;
    shape_ok = 1'b1;
    len      = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (!seen_f) begin
        if (is_dec[i])     len = len + 5'd1;
        else if (is_f[i])  seen_f = 1'b1;
        else               shape_ok = 1'b0;
      end else if (!is_f[i]) begin
        shape_ok = 1'b0;
      end
    end
    wf = shape_ok && (len >= 5'(MIN_LEN)) && (len <= 5'(MAX_LEN));
  end

  cls_t cls;
  logic match;

  always_comb begin
    if (&is_b)      cls = CLS_CMD_B;
    else if (&is_e) cls = CLS_TIMEOUT;
    else if (wf)    cls = CLS_WF;
    else            cls = CLS_MAL;
  end

  assign match = (cls == CLS_WF) && (pkt_q == senha_q);

  // Only a fresh edge is taken. It is dropped while another packet is pending
  // or while the lock is open / locked out; it is never queued.
  logic accepting_state;
  logic accept;

  assign accepting_state = (state_reg == IDLE) || (state_reg == CHG_AUTH) ||
                           (state_reg == CHG_NOVA);
  assign accept = digitos_valid && !valid_q && !(&in_is_f) &&
                  !pend_reg && accepting_state;

  logic [1:0] tent_inc;
  assign tent_inc = (tentativas == MAX_T) ? tentativas : tentativas + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pkt_q   <= '1;
      pend_reg <= 1'b0;
    end else begin
      valid_q <= digitos_valid;
      if (accept) pkt_q <= digitos_value;
      // A pending packet is always consumed in the following cycle.
      pend_reg <= pend_reg ? 1'b0 : accept;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      senha_q        <= SENHA_PADRAO;
      tranca_aberta  <= 1'b0;
      bloqueado      <= 1'b0;
      teclado_enable <= 1'b1;
      erro_pulso     <= 1'b0;
      senha_alterada <= 1'b0;
      tentativas     <= 2'd0;
    end else begin
      erro_pulso     <= 1'b0;
      senha_alterada <= 1'b0;
      case (state_reg)
        IDLE: if (pend_reg) begin
          if (match) begin
            state_reg     <= ABERTO;
            tranca_aberta <= 1'b1;
            timer_reg     <= TW'(T_ABERTO - 1);
            tentativas    <= 2'd0;
          end else if (cls == CLS_CMD_B) begin
            state_reg <= CHG_AUTH;
          end else if (cls == CLS_TIMEOUT) begin
            erro_pulso <= 1'b1;
          end else begin
            state_reg  <= FALHA;
            erro_pulso <= 1'b1;
            tentativas <= tent_inc;
          end
        end
        // Loaded with T-1 so the output is high for exactly T cycles.
        ABERTO: begin
          if (timer_reg == '0) begin
            state_reg     <= IDLE;
            tranca_aberta <= 1'b0;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        FALHA: begin
          if (tentativas == MAX_T) begin
            state_reg      <= BLOQUEIO;
            bloqueado      <= 1'b1;
            teclado_enable <= 1'b0;
            timer_reg      <= TW'(T_BLOQUEIO - 1);
          end else begin
            state_reg <= IDLE;
          end
        end
        BLOQUEIO: begin
          if (timer_reg == '0) begin
            state_reg      <= IDLE;
            bloqueado      <= 1'b0;
            teclado_enable <= 1'b1;
            tentativas     <= 2'd0;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        CHG_AUTH: if (pend_reg) begin
          if (match) begin
            state_reg <= CHG_NOVA;
          end else if (cls == CLS_CMD_B || cls == CLS_TIMEOUT) begin
            state_reg  <= IDLE;
            erro_pulso <= 1'b1;
          end else begin
            state_reg  <= FALHA;
            erro_pulso <= 1'b1;
            tentativas <= tent_inc;
          end
        end
        CHG_NOVA: if (pend_reg) begin
          state_reg <= IDLE;
          if (cls == CLS_WF) begin
            senha_q        <= pkt_q;
            senha_alterada <= 1'b1;
            tentativas     <= 2'd0;
          end else begin
            erro_pulso <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_verificador_de_senha.sv
module tb_verificador_de_senha;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] digitos_value;
  logic        digitos_valid;
  logic        tranca_aberta, bloqueado, teclado_enable;
  logic        erro_pulso, senha_alterada;
  logic [1:0]  tentativas;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  verificador_de_senha dut (
    .clk            (clk),
    .rst            (rst),
    .digitos_value  (digitos_value),
    .digitos_valid  (digitos_valid),
    .tranca_aberta  (tranca_aberta),
    .bloqueado      (bloqueado),
    .teclado_enable (teclado_enable),
    .erro_pulso     (erro_pulso),
    .senha_alterada (senha_alterada),
    .tentativas     (tentativas)
  );

  typedef struct {
    logic [79:0] pkt;
    logic        erro;
    logic        alt;
    logic        tranca;
    logic [1:0]  tent;
    bit          lock;  // this entry triggers lockout
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle valid pulse; returns 2 edges after the rising edge of valid.
  task automatic send(input logic [79:0] p);
    digitos_value = p;
    digitos_valid = 1'b1;
    tick();
    digitos_valid = 1'b0;
    digitos_value = '1;
    tick();
  endtask

  initial begin
    int n;
    int errs;
    logic [79:0] p1234;
    logic [79:0] p5678;
    p1234 = {{16{4'hF}}, 16'h1234};
    p5678 = {{16{4'hF}}, 16'h5678};

    tbl[0]  = '{{{16{4'hF}}, 16'h9999}, 1, 0, 0, 2'd1, 0};
    tbl[1]  = '{{{16{4'hF}}, 16'h9999}, 1, 0, 0, 2'd2, 0};
    tbl[2]  = '{{{16{4'hF}}, 16'h9999}, 1, 0, 0, 2'd3, 1};
    tbl[3]  = '{{20{4'hB}},             0, 0, 0, 2'd0, 0};
    tbl[4]  = '{{{16{4'hF}}, 16'h1234}, 0, 0, 0, 2'd0, 0};
    tbl[5]  = '{{{16{4'hF}}, 16'h5678}, 0, 1, 0, 2'd0, 0};
    tbl[6]  = '{{{16{4'hF}}, 16'h1234}, 1, 0, 0, 2'd1, 0};
    tbl[7]  = '{{{16{4'hF}}, 16'h5678}, 0, 0, 1, 2'd0, 0};
    tbl[8]  = '{{{17{4'hF}}, 12'h123},  1, 0, 0, 2'd1, 0};
    tbl[9]  = '{{{16{4'hF}}, 16'h1F34}, 1, 0, 0, 2'd2, 0};
    tbl[10] = '{{{16{4'hF}}, 16'hA234}, 1, 0, 0, 2'd3, 1};
    tbl[11] = '{{20{4'hE}},             1, 0, 0, 2'd0, 0};

    rst = 1'b1;
    digitos_valid = 1'b0;
    digitos_value = '1;
    #1;
    chk("rst_tranca", int'(tranca_aberta), 0);
    chk("rst_bloq", int'(bloqueado), 0);
    chk("rst_teclado", int'(teclado_enable), 1);
    chk("rst_erro", int'(erro_pulso), 0);
    chk("rst_alt", int'(senha_alterada), 0);
    chk("rst_tent", int'(tentativas), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Default password unlocks for exactly T_ABERTO cycles.
    send(p1234);
    $display("txn unlock_default: tranca=%0b tent=%0d", tranca_aberta, tentativas);
    chk("unlock_tranca", int'(tranca_aberta), 1);
    chk("unlock_tent", int'(tentativas), 0);
    chk("unlock_erro", int'(erro_pulso), 0);
    n = 0;
    while (tranca_aberta && n < 6000) begin n++; tick(); end
    chk("unlock_width", n, 5000);
    tick();

    // Held-high valid, then an all-F packet: one unlock, no error.
    errs = 0;
    n = 0;
    digitos_value = p1234;
    digitos_valid = 1'b1;
    repeat (3) begin tick(); n += int'(tranca_aberta); errs += int'(erro_pulso); end
    digitos_valid = 1'b0;
    tick(); n += int'(tranca_aberta); errs += int'(erro_pulso);
    digitos_value = '1;
    digitos_valid = 1'b1;
    tick(); n += int'(tranca_aberta); errs += int'(erro_pulso);
    digitos_valid = 1'b0;
    while (tranca_aberta && n < 6000) begin
      tick();
      n += int'(tranca_aberta);
      errs += int'(erro_pulso);
    end
    repeat (5) begin tick(); errs += int'(erro_pulso); end
    $display("txn held_valid: high_cycles=%0d errs=%0d", n, errs);
    chk("held_width", n, 5000);
    chk("held_errs", errs, 0);
    chk("held_relock", int'(tranca_aberta), 0);

    for (int i = 0; i < 12; i++) begin
      send(tbl[i].pkt);
      $display("txn vec%0d pkt=%h erro=%0b alt=%0b tranca=%0b tent=%0d",
               i, tbl[i].pkt, erro_pulso, senha_alterada, tranca_aberta, tentativas);
      chk($sformatf("v%0d_erro", i), int'(erro_pulso), int'(tbl[i].erro));
      chk($sformatf("v%0d_alt", i), int'(senha_alterada), int'(tbl[i].alt));
      chk($sformatf("v%0d_tranca", i), int'(tranca_aberta), int'(tbl[i].tranca));
      chk($sformatf("v%0d_tent", i), int'(tentativas), int'(tbl[i].tent));
      tick();
      if (tbl[i].lock) begin
        // Lockout width; a correct password mid-lockout must be dropped.
        n = 0;
        while (bloqueado && n < 30000) begin
          n++;
          if (n == 1) chk($sformatf("v%0d_teclado", i), int'(teclado_enable), 0);
          if (n == 100) begin digitos_value = p1234; digitos_valid = 1'b1; end
          if (n == 101) begin digitos_valid = 1'b0; digitos_value = '1; end
          tick();
        end
        chk($sformatf("v%0d_lock_width", i), n, 20000);
        repeat (3) tick();
        chk($sformatf("v%0d_after_lock_tranca", i), int'(tranca_aberta), 0);
        chk($sformatf("v%0d_after_lock_tent", i), int'(tentativas), 0);
        chk($sformatf("v%0d_after_lock_teclado", i), int'(teclado_enable), 1);
      end else begin
        tick();
        n = 0;
        while ((tranca_aberta || bloqueado) && n < 30000) begin n++; tick(); end
        chk($sformatf("v%0d_idle", i), int'({tranca_aberta, bloqueado}), 0);
      end
    end

    // Reset in the middle of an unlock restores the default password.
    send(p5678);
    chk("pre_rst_tranca", int'(tranca_aberta), 1);
    repeat (100) tick();
    #2 rst = 1'b1;
    #1;
    $display("txn mid_reset: tranca=%0b tent=%0d", tranca_aberta, tentativas);
    chk("mid_rst_tranca", int'(tranca_aberta), 0);
    chk("mid_rst_teclado", int'(teclado_enable), 1);
    tick();
    rst = 1'b0;
    tick();
    send(p1234);
    $display("txn default_after_reset: tranca=%0b", tranca_aberta);
    chk("post_rst_default", int'(tranca_aberta), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
